dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/rr_pick2.sv | 21 ++
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants and state encoding for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 256;
  localparam int DEF_TIMEOUT_CYCLES = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic idx,
  output logic valid
);

  always_comb begin
    // NOTE: defaults first so every path drives the outputs and no latch is inferred.
    idx   = 1'b0;
    valid = req0 | req1;
    if (req0 && req1) begin
      idx = ~last_grant;
    end else if (req1) begin
      idx = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one line-wide memory port, one transaction at a time.
// Define DMEM_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (rn_err_o on expiry).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_req_i,
  input  logic              r0_write_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_data_i,
  output logic              r0_ack_o,
  output logic [DATA_W-1:0] r0_data_o,
  output logic              r0_err_o,
  input  logic              r1_req_i,
  input  logic              r1_write_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_data_i,
  output logic              r1_ack_o,
  output logic [DATA_W-1:0] r1_data_o,
  output logic              r1_err_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t state;
  logic   grant;
  logic   last_grant;
  logic   pick_idx;
  logic   pick_valid;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
`endif

  rr_pick2 u_pick (
    .req0       (r0_req_i),
    .req1       (r1_req_i),
    .last_grant (last_grant),
    .idx        (pick_idx),
    .valid      (pick_valid)
  );

  // The latched request lives directly in the mem_* output registers, so it stays
  // stable from ISSUE through RESP without a separate copy.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst_i) begin
      state        <= ST_IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      r0_ack_o     <= 1'b0;
      r1_ack_o     <= 1'b0;
      r0_err_o     <= 1'b0;
      r1_err_o     <= 1'b0;
      r0_data_o    <= '0;
      r1_data_o    <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
      wd_cnt       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant        <= pick_idx;
            last_grant   <= pick_idx;
            mem_enable_o <= 1'b1;
            mem_write_o  <= pick_idx ? r1_write_i : r0_write_i;
            mem_addr_o   <= pick_idx ? r1_addr_i  : r0_addr_i;
            mem_data_o   <= pick_idx ? r1_data_i  : r0_data_i;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_enable_o <= 1'b0;
          state        <= ST_WAIT;
`ifdef DMEM_ARB_TIMEOUT_EN
          wd_cnt       <= '0;
`endif
        end
        ST_WAIT: begin
`ifdef DMEM_ARB_TIMEOUT_EN
          wd_cnt <= wd_cnt + 1'b1;
`endif
          if (mem_ack_i) begin
            if (!mem_write_o) begin
              if (grant) r1_data_o <= mem_data_i;
              else       r0_data_o <= mem_data_i;
            end
            if (grant) r1_ack_o <= 1'b1;
            else       r0_ack_o <= 1'b1;
            state <= ST_RESP;
          end
`ifdef DMEM_ARB_TIMEOUT_EN
          else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Watchdog expiry completes the transaction with an error; read data is untouched.
            if (grant) begin
              r1_ack_o <= 1'b1;
              r1_err_o <= 1'b1;
            end else begin
              r0_ack_o <= 1'b1;
              r0_err_o <= 1'b1;
            end
            state <= ST_RESP;
          end
`endif
        end
        ST_RESP: begin
          r0_ack_o <= 1'b0;
          r1_ack_o <= 1'b0;
          r0_err_o <= 1'b0;
          r1_err_o <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a line-indexed memory model of configurable ack delay.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TO = 15;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          r0_req_i, r0_write_i, r0_ack_o, r0_err_o;
  logic [AW-1:0] r0_addr_i;
  logic [DW-1:0] r0_data_i, r0_data_o;
  logic          r1_req_i, r1_write_i, r1_ack_o, r1_err_o;
  logic [AW-1:0] r1_addr_i;
  logic [DW-1:0] r1_data_i, r1_data_o;
  logic          mem_enable_o, mem_write_o, mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o, mem_data_i;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .r0_req_i     (r0_req_i),
    .r0_write_i   (r0_write_i),
    .r0_addr_i    (r0_addr_i),
    .r0_data_i    (r0_data_i),
    .r0_ack_o     (r0_ack_o),
    .r0_data_o    (r0_data_o),
    .r0_err_o     (r0_err_o),
    .r1_req_i     (r1_req_i),
    .r1_write_i   (r1_write_i),
    .r1_addr_i    (r1_addr_i),
    .r1_data_i    (r1_data_i),
    .r1_ack_o     (r1_ack_o),
    .r1_data_o    (r1_data_o),
    .r1_err_o     (r1_err_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] pattern(input int i);
    return {8{32'hC0DE_0000 + 32'(i)}};
  endfunction

  // Memory model: acks ack_delay cycles after the enable cycle; ack_delay of 0 never acks.
  int            ack_delay;
  int            mcnt;
  bit            pend;
  logic [3:0]    pidx;
  logic [DW-1:0] wline  [16];
  bit            wvalid [16];

  always @(posedge clk_i) begin
    #1;
    mem_ack_i = 1'b0;
    if (rst_i) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (mcnt == 1) begin
          mem_ack_i  = 1'b1;
          mem_data_i = wvalid[pidx] ? wline[pidx] : pattern(int'(pidx));
          pend       = 1'b0;
        end else begin
          mcnt--;
        end
      end
      if (mem_enable_o) begin
        pidx = mem_addr_o[8:5];
        if (mem_write_o) begin
          wline[pidx]  = mem_data_o;
          wvalid[pidx] = 1'b1;
        end
        if (ack_delay > 0) begin
          pend = 1'b1;
          mcnt = ack_delay;
        end
      end
    end
  end

  // Event monitor, sampled mid-cycle.
  int            cyc = 0;
  int            en_cnt = 0, en_cyc = 0, mack_cyc = 0;
  int            r0_n = 0, r1_n = 0, r0_cyc = 0, r1_cyc = 0;
  logic [AW-1:0] en_addr;
  logic          en_write;
  logic [DW-1:0] en_data;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (mem_enable_o) begin
      en_cnt++;
      en_cyc   = cyc;
      en_addr  = mem_addr_o;
      en_write = mem_write_o;
      en_data  = mem_data_o;
    end
    if (mem_ack_i) mack_cyc = cyc;
    if (r0_ack_o) begin r0_n++; r0_cyc = cyc; end
    if (r1_ack_o) begin r1_n++; r1_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_i);
      #1;
    end
  endtask

  task automatic issue(input bit who, input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data);
    if (who) begin
      r1_req_i = 1'b1; r1_write_i = wr; r1_addr_i = addr; r1_data_i = data;
    end else begin
      r0_req_i = 1'b1; r0_write_i = wr; r0_addr_i = addr; r0_data_i = data;
    end
  endtask

  task automatic wait_ack(input int budget, output bit who);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    who = 1'b0;
    while (!got && n < budget) begin
      tick(1);
      n++;
      if (r0_ack_o || r1_ack_o) begin
        got = 1'b1;
        who = r1_ack_o;
        check("ack_exclusive", {255'd0, r0_ack_o & r1_ack_o}, '0);
      end
    end
    check("ack_within_budget", {255'd0, got}, 1);
    r0_req_i = 1'b0;
    r1_req_i = 1'b0;
  endtask

  bit            who;
  int            base_en, base_r0, base_r1;
  logic [DW-1:0] r0_keep;

  initial begin
    rst_i = 1'b1;
    ack_delay = 8;
    r0_req_i = 1'b0; r0_write_i = 1'b0; r0_addr_i = '0; r0_data_i = '0;
    r1_req_i = 1'b0; r1_write_i = 1'b0; r1_addr_i = '0; r1_data_i = '0;
    tick(3);
    check("rst_r0_ack", r0_ack_o, 0);
    check("rst_r1_ack", r1_ack_o, 0);
    check("rst_mem_en", mem_enable_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_r0_data", r0_data_o, 0);
    check("rst_r1_err", r1_err_o, 0);
    rst_i = 1'b0;
    tick(1);

    // r0 read of line 1, memory acks 8 cycles after enable.
    base_en = en_cnt; base_r1 = r1_n;
    issue(0, 0, 32'h20, '0);
    wait_ack(60, who);
    check("s1_who", {255'd0, who}, 0);
    check("s1_enable_cycles", en_cnt - base_en, 1);
    check("s1_addr", en_addr, 32'h20);
    check("s1_write", en_write, 0);
    check("s1_mem_delay", mack_cyc - en_cyc, 8);
    check("s1_ack_latency", r0_cyc - mack_cyc, 1);
    check("s1_data", r0_data_o, pattern(1));
    check("s1_err", r0_err_o, 0);
    check("s1_addr_held", mem_addr_o, 32'h20);
    check("s1_r1_quiet", r1_n - base_r1, 0);
    tick(1);
    check("s1_ack_one_cycle", r0_ack_o, 0);

    // r1 write then read back of 0x40.
    ack_delay = 3; base_r0 = r0_n;
    issue(1, 1, 32'h40, {32{8'hA5}});
    wait_ack(60, who);
    check("s2w_who", {255'd0, who}, 1);
    check("s2w_write", en_write, 1);
    check("s2w_wdata", en_data, {32{8'hA5}});
    check("s2w_data_unchanged", r1_data_o, 0);
    tick(1);
    issue(1, 0, 32'h40, '0);
    wait_ack(60, who);
    check("s2r_who", {255'd0, who}, 1);
    check("s2r_write", en_write, 0);
    check("s2r_data", r1_data_o, {32{8'hA5}});
    check("s2_r0_quiet", r0_n - base_r0, 0);
    check("s2_r0_data_kept", r0_data_o, pattern(1));
    tick(1);

    // Simultaneous requests: grants alternate starting with r0 (r1 was granted last).
    ack_delay = 2;
    for (int k = 0; k < 4; k++) begin
      issue(0, 0, 32'h60, '0);
      issue(1, 0, 32'hA0, '0);
      wait_ack(60, who);
      check($sformatf("s3_grant%0d", k), {255'd0, who}, (k % 2 == 1) ? 1 : 0);
      tick(1);
    end
    check("s3_r0_data", r0_data_o, pattern(3));
    check("s3_r1_data", r1_data_o, pattern(5));

    // Reset three cycles into WAIT aborts the transaction.
    ack_delay = 0; base_r0 = r0_n; base_r1 = r1_n;
    issue(0, 0, 32'h20, '0);
    for (int n = 0; n < 20 && !mem_enable_o; n++) tick(1);
    check("s4_issue_seen", mem_enable_o, 1);
    tick(3);
    rst_i = 1'b1;
    r0_req_i = 1'b0;
    tick(1);
    check("s4_mem_en", mem_enable_o, 0);
    check("s4_mem_write", mem_write_o, 0);
    check("s4_mem_addr", mem_addr_o, 0);
    check("s4_mem_data", mem_data_o, 0);
    check("s4_r0_data", r0_data_o, 0);
    check("s4_r1_data", r1_data_o, 0);
    check("s4_acks", {254'd0, r1_ack_o, r0_ack_o}, 0);
    check("s4_errs", {254'd0, r1_err_o, r0_err_o}, 0);
    check("s4_no_ack_pulse", (r0_n - base_r0) + (r1_n - base_r1), 0);
    rst_i = 1'b0;
    ack_delay = 4;
    issue(1, 0, 32'h20, '0);
    wait_ack(60, who);
    check("s4_after_who", {255'd0, who}, 1);
    check("s4_after_data", r1_data_o, pattern(1));
    check("s4_r0_quiet", r0_n - base_r0, 0);
    tick(1);

    // Memory that never acks.
    ack_delay = 0; base_r0 = r0_n; r0_keep = r0_data_o;
    issue(0, 0, 32'h80, '0);
`ifdef DMEM_ARB_TIMEOUT_EN
    wait_ack(TO + 20, who);
    check("s5_who", {255'd0, who}, 0);
    check("s5_err", r0_err_o, 1);
    check("s5_timeout_cycle", r0_cyc - en_cyc, TO + 1);
    check("s5_data_kept", r0_data_o, r0_keep);
    tick(1);
    check("s5_err_cleared", r0_err_o, 0);
    ack_delay = 2;
    issue(0, 0, 32'h80, '0);
    wait_ack(60, who);
    check("s5_normal_err", r0_err_o, 0);
    check("s5_normal_data", r0_data_o, pattern(4));
`else
    tick(100);
    check("s5_no_ack", (r0_n - base_r0) + r1_n - r1_n, 0);
    check("s5_err", r0_err_o, 0);
    check("s5_data_kept", r0_data_o, r0_keep);
    r0_req_i = 1'b0;
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
`endif
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
